sw_host_feeder: RTL and testbench

// - Host-side driver of the Smith-Waterman accelerator user/data interface: the transmitter for its T/S/param inputs, receiver of its result.
// - Packs a host base stream (2 bits/base) into 18-bit T words and PE_SIZE-base S chunks.
// - Sequences param load -> set_t -> start_cal, serves S chunk requests, captures the score.
// - Sits between the host bus adapter and the accelerator top.

---
 rtl/sw_host_feeder_pkg.sv | 17 +
 rtl/sw_host_feeder_chunk_fifo.sv | 42 ++++
 rtl/sw_host_feeder.sv | 189 ++++++++++++++++++
 tb/tb_sw_host_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_host_feeder_pkg.sv
// sw_host_feeder_pkg: shared encodings and sizes for the Smith-Waterman host feeder
package sw_host_feeder_pkg;
  localparam int PE_SIZE = 4;
  localparam int PE_SIZE_LOG = 2;
  localparam int VEF_BIT = 16;
  localparam int MATCH_BIT = 4;
  localparam int S_W = 2 * PE_SIZE;
  localparam int CNT_W = PE_SIZE_LOG + 1;
  localparam int CHUNK_W = CNT_W + S_W;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;
  localparam logic [1:0] T_LAST = 2'b11;
  typedef enum logic [1:0] {BASE_A, BASE_C, BASE_G, BASE_T} base_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PARAM, ST_SETT, ST_T, ST_WAIT_T, ST_LOAD_S, ST_CALC, ST_DONE
  } state_e;
endpackage

// File: rtl/sw_host_feeder_chunk_fifo.sv
// sw_chunk_fifo: two-entry FIFO of {base count, S chunk} with same-cycle push and pop
module sw_chunk_fifo
  import sw_host_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [CHUNK_W-1:0] i_din,
  input  logic               i_pop,
  output logic [CHUNK_W-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty
);
  logic [CHUNK_W-1:0] r_mem [2];
  logic r_wp, r_rp;
  logic [1:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == 2'd2;
  assign o_empty = r_cnt == 2'd0;
  assign o_dout = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  // storage and pointer update; clear drops any leftover chunks between jobs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_clr) begin
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_din;
      r_wp <= r_wp ^ w_push;
      r_rp <= r_rp ^ w_pop;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: rtl/sw_host_feeder.sv
// sw_host_feeder: packs host bases into T words and S chunks and sequences the SW accelerator job
module sw_host_feeder
  import sw_host_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           h_base,
  input  logic                 h_base_valid,
  input  logic                 h_base_last,
  output logic                 h_base_ready,
  input  logic                 h_start,
  input  logic [MATCH_BIT-1:0] h_match,
  input  logic [MATCH_BIT-1:0] h_mismatch,
  input  logic [7:0]           h_alpha,
  input  logic [7:0]           h_beta,
  output logic [VEF_BIT-1:0]   h_result,
  output logic                 h_done,
  output logic                 a_param_valid,
  output logic [MATCH_BIT-1:0] a_match,
  output logic [MATCH_BIT-1:0] a_mismatch,
  output logic [7:0]           a_alpha,
  output logic [7:0]           a_beta,
  output logic                 a_set_t,
  output logic [17:0]          a_t,
  output logic                 a_start_cal,
  input  logic                 a_busy,
  input  logic                 a_request_s,
  output logic [S_W-1:0]       a_s,
  output logic [CNT_W-1:0]     a_s_valid,
  input  logic [VEF_BIT-1:0]   a_result,
  input  logic                 a_valid
);
  state_e r_state;
  logic r_param_valid, r_set_t, r_start_cal, r_done, r_pend, r_drain;
  logic [MATCH_BIT-1:0] r_match, r_mismatch;
  logic [7:0] r_alpha, r_beta;
  logic [17:0] r_t;
  logic [15:0] r_tbuf;
  logic [2:0] r_tcnt;
  logic [1:0] r_wait;
  logic [S_W-1:0] r_sbuf, r_s;
  logic [PE_SIZE_LOG-1:0] r_scnt;
  logic [CNT_W-1:0] r_s_valid;
  logic [VEF_BIT-1:0] r_result;
  logic w_ready, w_acc, w_tend, w_temit, w_sacc, w_sclose, w_req, w_pop, w_byp, w_push;
  logic w_full, w_empty, w_clr;
  logic [15:0] w_tbuf;
  logic [S_W-1:0] w_sbuf;
  logic [CHUNK_W-1:0] w_chunk, w_head;
  assign w_ready = (r_state == ST_T) || (r_state == ST_LOAD_S && !w_full) ||
                   (r_state == ST_DONE && r_drain);
  assign w_acc = h_base_valid && w_ready;
  // a last flag without a valid base still closes T, as a zero-base last word
  assign w_tend = r_state == ST_T && h_base_last;
  assign w_temit = w_tend || (r_state == ST_T && h_base_valid && r_tcnt == 3'd7);
  assign w_tbuf = r_tbuf | (16'(h_base & {2{h_base_valid}}) << {r_tcnt, 1'b0});
  assign w_sacc = r_state == ST_LOAD_S && w_acc;
  assign w_sclose = w_sacc && (r_scnt == PE_SIZE_LOG'(PE_SIZE - 1) || h_base_last);
  assign w_sbuf = r_sbuf | (S_W'(h_base) << {r_scnt, 1'b0});
  assign w_chunk = {CNT_W'(r_scnt) + CNT_W'(1), w_sbuf};
  assign w_req = a_request_s || r_pend;
  assign w_pop = w_req && !w_empty;
  // a chunk closing into an empty FIFO while a request waits goes straight out
  assign w_byp = w_req && w_empty && w_sclose;
  assign w_push = w_sclose && !w_byp;
  assign w_clr = r_state == ST_WAIT_T;
  assign h_base_ready = w_ready;
  assign h_result = r_result;
  assign h_done = r_done;
  assign a_param_valid = r_param_valid;
  assign a_match = r_match;
  assign a_mismatch = r_mismatch;
  assign a_alpha = r_alpha;
  assign a_beta = r_beta;
  assign a_set_t = r_set_t;
  assign a_t = r_t;
  assign a_start_cal = r_start_cal;
  assign a_s = r_s;
  assign a_s_valid = r_s_valid;
  sw_chunk_fifo u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_push (w_push),
    .i_din  (w_chunk),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  // job sequencer with T packing, S chunk assembly, request service and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_param_valid <= 1'b0;
      r_set_t <= 1'b0;
      r_start_cal <= 1'b0;
      r_done <= 1'b0;
      r_pend <= 1'b0;
      r_drain <= 1'b0;
      r_match <= '0;
      r_mismatch <= '0;
      r_alpha <= '0;
      r_beta <= '0;
      r_t <= {T_IDLE, 16'd0};
      r_tbuf <= '0;
      r_tcnt <= '0;
      r_wait <= '0;
      r_sbuf <= '0;
      r_s <= '0;
      r_scnt <= '0;
      r_s_valid <= '0;
      r_result <= '0;
    end else begin
      r_param_valid <= 1'b0;
      r_set_t <= 1'b0;
      r_start_cal <= 1'b0;
      r_done <= 1'b0;
      r_t <= {T_IDLE, 16'd0};
      {r_s_valid, r_s} <= w_pop ? w_head : w_byp ? w_chunk : '0;
      r_pend <= r_state == ST_LOAD_S && w_req && w_empty && !w_sclose;
      if (w_sacc) begin
        r_scnt <= w_sclose ? '0 : r_scnt + 1'b1;
        r_sbuf <= w_sclose ? '0 : w_sbuf;
      end
      case (r_state)
        ST_IDLE:
          if (h_start) begin
            r_match <= h_match;
            r_mismatch <= h_mismatch;
            r_alpha <= h_alpha;
            r_beta <= h_beta;
            r_param_valid <= 1'b1;
            r_state <= ST_PARAM;
          end
        ST_PARAM: begin
          r_set_t <= 1'b1;
          r_state <= ST_SETT;
        end
        ST_SETT: begin
          r_tbuf <= '0;
          r_tcnt <= '0;
          r_state <= ST_T;
        end
        ST_T: begin
          if (w_temit) begin
            r_t <= {w_tend ? T_LAST : T_DATA, w_tbuf};
            r_tbuf <= '0;
            r_tcnt <= '0;
          end else if (h_base_valid) begin
            r_tbuf <= w_tbuf;
            r_tcnt <= r_tcnt + 3'd1;
          end
          if (w_tend) begin
            r_wait <= '0;
            r_state <= ST_WAIT_T;
          end
        end
        ST_WAIT_T: begin
          r_scnt <= '0;
          r_sbuf <= '0;
          if (r_wait != 2'd2) r_wait <= r_wait + 2'd1;
          else if (!a_busy) begin
            r_start_cal <= 1'b1;
            r_state <= ST_LOAD_S;
          end
        end
        ST_LOAD_S:
          if (a_valid) begin
            r_result <= a_result;
            r_done <= 1'b1;
            r_drain <= !(w_acc && h_base_last);
            r_state <= ST_DONE;
          end else if (w_sacc && h_base_last) r_state <= ST_CALC;
        ST_CALC:
          if (a_valid) begin
            r_result <= a_result;
            r_done <= 1'b1;
            r_drain <= 1'b0;
            r_state <= ST_DONE;
          end
        ST_DONE: begin
          if (w_acc && h_base_last) r_drain <= 1'b0;
          if (!a_busy && !r_drain) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sw_host_feeder.sv
// tb_sw_host_feeder: table-driven and directed checks of the SW host feeder
module tb_sw_host_feeder;
  import sw_host_feeder_pkg::*;
  logic clk, rst_n;
  logic [1:0] h_base;
  logic h_base_valid, h_base_last, h_base_ready, h_start, h_done;
  logic [MATCH_BIT-1:0] h_match, h_mismatch, a_match, a_mismatch;
  logic [7:0] h_alpha, h_beta, a_alpha, a_beta;
  logic [VEF_BIT-1:0] h_result, a_result;
  logic a_param_valid, a_set_t, a_start_cal, a_busy, a_request_s, a_valid;
  logic [17:0] a_t;
  logic [S_W-1:0] a_s;
  logic [CNT_W-1:0] a_s_valid;
  int n_pass = 0;
  int n_tot = 0;
  typedef struct {
    logic v, l;
    logic [1:0] b;
    logic req, rdy;
    logic [17:0] t;
    logic st;
    logic [2:0] sv;
    logic [7:0] s;
  } vec_t;
  vec_t q[$];
  sw_host_feeder dut (
    .clk(clk), .rst_n(rst_n), .h_base(h_base), .h_base_valid(h_base_valid),
    .h_base_last(h_base_last), .h_base_ready(h_base_ready), .h_start(h_start),
    .h_match(h_match), .h_mismatch(h_mismatch), .h_alpha(h_alpha), .h_beta(h_beta),
    .h_result(h_result), .h_done(h_done), .a_param_valid(a_param_valid),
    .a_match(a_match), .a_mismatch(a_mismatch), .a_alpha(a_alpha), .a_beta(a_beta),
    .a_set_t(a_set_t), .a_t(a_t), .a_start_cal(a_start_cal), .a_busy(a_busy),
    .a_request_s(a_request_s), .a_s(a_s), .a_s_valid(a_s_valid),
    .a_result(a_result), .a_valid(a_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end
  function automatic vec_t mk(input logic v, l, input logic [1:0] b, input logic req, rdy,
                              input logic [17:0] t, input logic st, input logic [2:0] sv,
                              input logic [7:0] s);
    return '{v, l, b, req, rdy, t, st, sv, s};
  endfunction
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, {h_base_ready, h_result, h_done, a_param_valid, a_match, a_mismatch, a_alpha,
             a_beta, a_set_t, a_t, a_start_cal, a_s, a_s_valid}, 80'd0);
  endtask
  task automatic run(input int a, input int b);
    for (int i = a; i < b; i++) begin
      h_base_valid = q[i].v;
      h_base_last = q[i].l;
      h_base = q[i].b;
      a_request_s = q[i].req;
      step;
      chk($sformatf("row%0d_ready", i), h_base_ready, q[i].rdy);
      chk($sformatf("row%0d_t", i), a_t, q[i].t);
      chk($sformatf("row%0d_start", i), a_start_cal, q[i].st);
      chk($sformatf("row%0d_sv", i), a_s_valid, q[i].sv);
      chk($sformatf("row%0d_s", i), a_s, q[i].s);
    end
    h_base_valid = 0;
    h_base_last = 0;
    a_request_s = 0;
  endtask
  task automatic start_job(input string nm, input logic [23:0] p);
    {h_match, h_mismatch, h_alpha, h_beta} = p;
    h_start = 1;
    step;
    h_start = 0;
    chk({nm, "_pv"}, a_param_valid, 1);
    chk({nm, "_params"}, {a_match, a_mismatch, a_alpha, a_beta}, p);
    step;
    chk({nm, "_pv_off"}, a_param_valid, 0);
    chk({nm, "_set_t"}, a_set_t, 1);
    step;
    chk({nm, "_set_t_off"}, a_set_t, 0);
    chk({nm, "_t_ready"}, h_base_ready, 1);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 2'(i), 0, 1, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_A, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_C, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_G, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_T, 0, 1, 18'h1E4E4, 0, 0, 0));
    q.push_back(mk(1, 1, BASE_A, 0, 0, 18'h30000, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
    q.push_back(mk(1, 0, BASE_A, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_C, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_G, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_T, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_T, 1, 1, 0, 0, 4, 8'hE4));
    q.push_back(mk(1, 0, BASE_G, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_C, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_A, 1, 1, 0, 0, 4, 8'h1B));
    q.push_back(mk(1, 0, BASE_G, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 1, BASE_T, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 8'h0E));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) q.push_back(mk(1, 0, BASE_T, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 0, BASE_T, 0, 1, 18'h1FFFF, 0, 0, 0));
    q.push_back(mk(0, 1, 0, 0, 0, 18'h30000, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
    rst_n = 0;
    h_start = 1;
    {h_base, h_base_valid, h_base_last, h_match, h_mismatch, h_alpha, h_beta} = '0;
    {a_busy, a_request_s, a_result, a_valid} = '0;
    repeat (3) step;
    chk_zero("reset_outputs");
    h_start = 0;
    rst_n = 1;
    step;
    chk_zero("post_reset_idle");
    start_job("j1", {4'd2, 4'd1, 8'd3, 8'd1});
    run(0, 28);
    a_valid = 1;
    a_result = 16'd37;
    a_busy = 1;
    step;
    chk("j1_done", h_done, 1);
    chk("j1_result", h_result, 16'd37);
    a_valid = 0;
    a_result = 0;
    h_start = 1;
    step;
    chk("j1_done_pulse", h_done, 0);
    chk("j1_start_ignored", a_param_valid, 0);
    h_start = 0;
    step;
    chk("j1_result_hold", h_result, 16'd37);
    a_busy = 0;
    step;
    start_job("j2", {4'd5, 4'd3, 8'd11, 8'd2});
    run(28, 40);
    a_request_s = 1;
    step;
    a_request_s = 0;
    chk("stall_req", a_s_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("stall%0d", i), a_s_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      h_base_valid = 1;
      h_base = (i == 0) ? BASE_G : (i == 1) ? BASE_A : (i == 2) ? BASE_T : BASE_C;
      step;
      chk($sformatf("stall_sv%0d", i), a_s_valid, (i == 3) ? 3'd4 : 3'd0);
    end
    h_base_valid = 0;
    chk("stall_chunk", a_s, 8'h72);
    step;
    chk("stall_cleared", a_s_valid, 0);
    for (int i = 0; i < 8; i++) begin
      h_base_valid = 1;
      h_base = 2'(i);
      step;
    end
    h_base_valid = 0;
    chk("fifo_full_ready", h_base_ready, 0);
    rst_n = 0;
    step;
    chk_zero("midjob_reset");
    rst_n = 1;
    step;
    start_job("j3", {4'd7, 4'd1, 8'd3, 8'd4});
    h_base_valid = 1;
    h_base_last = 1;
    h_base = BASE_T;
    step;
    h_base_valid = 0;
    h_base_last = 0;
    chk("j3_t", a_t, 18'h30003);
    for (int k = 0; k < 10 && !a_start_cal; k++) step;
    chk("j3_start", a_start_cal, 1);
    h_base_valid = 1;
    h_base_last = 1;
    h_base = BASE_C;
    a_request_s = 1;
    step;
    {h_base_valid, h_base_last, a_request_s} = '0;
    chk("j3_bypass_sv", a_s_valid, 1);
    chk("j3_bypass_s", a_s, 8'h01);
    a_valid = 1;
    a_result = 16'd5;
    step;
    a_valid = 0;
    chk("j3_result", h_result, 16'd5);
    chk("j3_done", h_done, 1);
    step;
    chk("j3_done_pulse", h_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
